// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: two-stage immediate generator between decode and the ALU
// operand mux. Stage 1 captures the raw immediate, mode and tag. Stage 2
// forms the OUT_W-bit operand and registers it with its tag and overflow flag.
//
// Handshake (both ports): a transfer happens on a rising edge where valid and
// ready are both 1. A producer holds valid and its payload stable until the
// transfer. Ready never depends on valid. While Out_valid=1 and Out_ready=0,
// Ext_imm, Tag_out and Ovf hold their values.
module imm_extend_pipe #(
  parameter int IN_W  = 15,
  parameter int OUT_W = 32,
  parameter int SHIFT = 2,
  parameter int TAG_W = 5
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             In_valid,
  output logic             In_ready,
  input  logic [IN_W-1:0]  Imm,
  input  logic [1:0]       Mode,
  input  logic [TAG_W-1:0] Tag_in,
  output logic             Out_valid,
  input  logic             Out_ready,
  output logic [OUT_W-1:0] Ext_imm,
  output logic [TAG_W-1:0] Tag_out,
  output logic             Ovf
);

  // Wide enough to hold the sign-extended immediate after the left shift,
  // so the bits pushed out of the top stay visible for overflow detection.
  localparam int WIDE_W = OUT_W + SHIFT;

  if (IN_W < 1 || IN_W > OUT_W) begin : g_bad_in_w
    $error("imm_extend_pipe: IN_W must satisfy 1 <= IN_W <= OUT_W");
  end
  if (SHIFT < 0 || SHIFT > OUT_W - 1) begin : g_bad_shift
    $error("imm_extend_pipe: SHIFT must be in 0..OUT_W-1");
  end

  // Stage 1 registers
  logic             s1_valid;
  logic [IN_W-1:0]  s1_imm;
  logic [1:0]       s1_mode;
  logic [TAG_W-1:0] s1_tag;

  // Stage 2 valid; its data registers are the output ports themselves
  logic             s2_valid;

  logic             s1_adv;
  logic             s2_adv;

  // Stage 2 next-value datapath
  logic signed [IN_W-1:0] imm_s;
  logic [WIDE_W-1:0]      wide_sext;
  logic [WIDE_W-1:0]      wide_shift;
  logic [SHIFT:0]         wide_top;
  logic [OUT_W-1:0]       ext_next;
  logic                   ovf_next;

  // A stage may take new contents when it is empty or its contents move on.
  assign s2_adv    = !s2_valid || Out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  // Held low while reset is asserted so nothing is offered as accepted during
  // the reset cycle; state is cleared by then, so it reads 1 right after.
  assign In_ready  = Rst_n && s1_adv;
  assign Out_valid = s2_valid;

  // Stage 1: capture the request whenever the stage is free to advance.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      s1_valid <= 1'b0;
      s1_imm   <= '0;
      s1_mode  <= '0;
      s1_tag   <= '0;
    end else if (s1_adv) begin
      s1_valid <= In_valid;
      if (In_valid) begin
        s1_imm  <= Imm;
        s1_mode <= Mode;
        s1_tag  <= Tag_in;
      end
    end
  end

  // Extension per mode. The top SHIFT+1 bits of the widened, shifted value
  // are the discarded bits plus the new sign bit; overflow means they differ.
  always_comb begin
    imm_s      = s1_imm;
    wide_sext  = WIDE_W'(imm_s);
    wide_shift = wide_sext << SHIFT;
    wide_top   = wide_shift[WIDE_W-1 -: SHIFT+1];
    ext_next   = '0;
    ovf_next   = 1'b0;
    case (s1_mode)
      2'b00: ext_next = OUT_W'(imm_s);
      2'b01: ext_next = OUT_W'(s1_imm);
      2'b10: begin
        ext_next = wide_shift[OUT_W-1:0];
        ovf_next = !((&wide_top) || !(|wide_top));
      end
      2'b11: ext_next = OUT_W'(s1_imm) << (OUT_W - IN_W);
      default: ext_next = '0;
    endcase
  end

  // Stage 2: load the computed result, or a bubble when stage 1 is empty.
  // Data registers only change on a real load, so they hold under stall.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      s2_valid <= 1'b0;
      Ext_imm  <= '0;
      Tag_out  <= '0;
      Ovf      <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        Ext_imm <= ext_next;
        Tag_out <= s1_tag;
        Ovf     <= ovf_next;
      end
    end
  end

endmodule
